uart_rx_frame_parser: RTL

UART_RX_FRAME_PARSER -- requirements
Module: uart_rx_frame_parser

---
 rtl/uart_frame_pkg.sv | 27 ++
 rtl/uart_frame_buf.sv | 46 ++++
 rtl/uart_rx_frame_parser.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared constants and types for the UART RX frame parser
//
// Purpose: start-of-frame marker, parser state encoding, error cause
// encoding and the default maximum payload length.
// Ports: none (package).

package uart_frame_pkg;

  localparam logic [7:0] SOF             = 8'hA5;
  localparam int         DEFAULT_MAX_LEN = 16;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_LEN  = 2'b01,
    ERR_CHK  = 2'b10,
    ERR_TMO  = 2'b11
  } err_e;

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload buffer, one write port and one async read port
//
// Purpose: holds the payload of the frame being received until its checksum
// has been verified, then supplies it byte by byte during drain.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write index
//   wdata - write byte
//   raddr - read index (combinational read)
//   rdata - byte at raddr, 0x00 for an index beyond the array

module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  // The index ports are sized to hold the value DEPTH, so they can be one
  // bit wider than the array needs; only the low bits address the array.
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] mem_q [DEPTH];

  // Payload storage needs no reset: a byte is only ever read after the
  // current frame has written it.
  always_ff @(posedge clk) begin
    if (we && (waddr < AW'(DEPTH))) begin
      mem_q[waddr[MW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (raddr < AW'(DEPTH)) begin
      rdata = mem_q[raddr[MW-1:0]];
    end
  end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// rtl/uart_rx_frame_parser.sv - SOF/LEN/payload/XOR-checksum frame parser on a UART RX FIFO
//
// Purpose: pops bytes from a first-word-fall-through RX FIFO, recognises
// frames of the form A5, LEN, LEN payload bytes, CHK (CHK = XOR of LEN and
// payload), buffers the payload and releases it on a valid/ready stream only
// once the checksum has matched. Bad length, checksum mismatch and
// inter-byte timeout each discard the frame with a one-cycle frame_err.
// Ports:
//   clk           - clock, rising edge
//   rst           - asynchronous active-low reset
//   rx_dout       - FIFO head byte, valid while rx_fifo_empty = 0
//   rx_fifo_empty - FIFO holds no byte
//   rd_uart       - pops the FIFO head in the cycle it is high
//   out_data      - verified payload byte
//   out_valid     - qualifies out_data
//   out_ready     - consumer accept
//   out_last      - final payload byte of the frame
//   frame_err     - one-cycle pulse on a discarded frame
//   err_code      - cause of the last error (01 length, 10 checksum, 11 timeout)

module uart_rx_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN     = DEFAULT_MAX_LEN,
  parameter int TIMEOUT_CYC = 104170
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_dout,
  input  logic       rx_fifo_empty,
  output logic       rd_uart,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   len_q, len_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic [7:0]      chk_q, chk_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            hunt_wait_q, hunt_wait_d;
  logic            frame_err_q, frame_err_d;
  err_e            err_code_q, err_code_d;

  logic            err_hit;
  err_e            err_kind;
  logic            buf_we;
  logic [7:0]      buf_rdata;
  logic [IW-1:0]   last_idx;
  logic            tmo_expired;

  assign last_idx    = len_q - IW'(1);
  assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYC));

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (IW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_idx_q),
    .wdata (rx_dout),
    .raddr (rd_idx_q),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HUNT;
      len_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      chk_q       <= 8'h00;
      tmo_q       <= '0;
      hunt_wait_q <= 1'b1;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      hunt_wait_q <= hunt_wait_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    chk_d       = chk_q;
    tmo_d       = '0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    err_hit     = 1'b0;
    err_kind    = ERR_NONE;
    buf_we      = 1'b0;
    rd_uart     = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = 8'h00;

    case (state_q)
      ST_HUNT: begin
        // The first HUNT cycle never pops, so the error pulse (registered,
        // visible in that cycle) never coincides with a pop, and the first
        // pop after reset release lands on the second edge.
        rd_uart = ~rx_fifo_empty & ~hunt_wait_q;
        if (rd_uart && (rx_dout == SOF)) begin
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        rd_uart = ~rx_fifo_empty;
        if (rd_uart) begin
          if ((rx_dout == 8'h00) || (rx_dout > 8'(MAX_LEN))) begin
            err_hit  = 1'b1;
            err_kind = ERR_LEN;
          end else begin
            len_d    = IW'(rx_dout);
            chk_d    = rx_dout;
            wr_idx_d = '0;
            state_d  = ST_PAYLOAD;
          end
        end else if (tmo_expired) begin
          err_hit  = 1'b1;
          err_kind = ERR_TMO;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_PAYLOAD: begin
        // SOF values are ordinary data here; no resync inside a frame.
        rd_uart = ~rx_fifo_empty;
        if (rd_uart) begin
          buf_we   = 1'b1;
          chk_d    = chk_q ^ rx_dout;
          wr_idx_d = wr_idx_q + IW'(1);
          if (wr_idx_q == last_idx) begin
            state_d = ST_CHK;
          end
        end else if (tmo_expired) begin
          err_hit  = 1'b1;
          err_kind = ERR_TMO;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_CHK: begin
        rd_uart = ~rx_fifo_empty;
        if (rd_uart) begin
          if (rx_dout == chk_q) begin
            rd_idx_d = '0;
            state_d  = ST_DRAIN;
          end else begin
            err_hit  = 1'b1;
            err_kind = ERR_CHK;
          end
        end else if (tmo_expired) begin
          err_hit  = 1'b1;
          err_kind = ERR_TMO;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_DRAIN: begin
        // Outputs are pure functions of state and read index, so they stay
        // put while the consumer stalls.
        out_valid = 1'b1;
        out_data  = buf_rdata;
        out_last  = (rd_idx_q == last_idx);
        if (out_ready) begin
          rd_idx_d = rd_idx_q + IW'(1);
          if (out_last) begin
            state_d = ST_HUNT;
          end
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase

    if (err_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = err_kind;
      state_d     = ST_HUNT;
    end

    hunt_wait_d = (state_d == ST_HUNT) && (state_q != ST_HUNT);
  end

  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule
